// File: rtl/memory_dp.sv
// memory_dp: dual-port byte-lane RAM with pipelined reads and a post-reset zero-fill sequencer
module memory_dp #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_SIZE = 8,
  parameter int LANE_SIZE = 8,
  parameter int READ_LATENCY = 1,
  parameter int INIT_ON_RESET = 1,
  localparam int LANES = WORD_SIZE / LANE_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 init_busy,
  input  logic                 a_req,
  input  logic                 a_we,
  input  logic [LANES-1:0]     a_be,
  input  logic [ADDR_SIZE-1:0] a_addr,
  input  logic [WORD_SIZE-1:0] a_wdata,
  output logic                 a_ready,
  output logic                 a_rvalid,
  output logic [WORD_SIZE-1:0] a_rdata,
  input  logic                 b_req,
  input  logic                 b_we,
  input  logic [LANES-1:0]     b_be,
  input  logic [ADDR_SIZE-1:0] b_addr,
  input  logic [WORD_SIZE-1:0] b_wdata,
  output logic                 b_ready,
  output logic                 b_rvalid,
  output logic [WORD_SIZE-1:0] b_rdata
);
  if (READ_LATENCY < 1 || READ_LATENCY > 3 || WORD_SIZE % LANE_SIZE != 0) begin : g_bad_params
    $error("memory_dp: READ_LATENCY must be 1..3 and WORD_SIZE a multiple of LANE_SIZE");
  end

  typedef enum logic {INIT, READY} state_t;

  localparam logic [ADDR_SIZE:0] CNT_LAST = {1'b0, {ADDR_SIZE{1'b1}}};
  localparam logic [ADDR_SIZE:0] CNT_ONE = 1;

  state_t                              state_q;
  logic   [ADDR_SIZE:0]                cnt_q;
  logic                                ready_q;
  logic   [WORD_SIZE-1:0]              mem_q [2**ADDR_SIZE];
  logic   [1:0][READ_LATENCY-1:0]      vld_q;
  logic   [WORD_SIZE-1:0]              dat_q [2][READ_LATENCY];
  logic   [1:0]                        rd, wr;
  logic   [1:0][ADDR_SIZE-1:0]         addr;
  logic   [1:0][WORD_SIZE-1:0]         wdata;
  logic   [1:0][LANES-1:0]             be;

  // Index 0 is port A, index 1 is port B throughout.
  assign addr  = {b_addr, a_addr};
  assign wdata = {b_wdata, a_wdata};
  assign be    = {b_be, a_be};
  assign rd    = {b_req & ~b_we, a_req & ~a_we} & {2{ready_q}};
  assign wr    = {b_req & b_we, a_req & a_we} & {2{ready_q}};

  assign a_ready  = ready_q;
  assign b_ready  = ready_q;
  assign a_rvalid = vld_q[0][READ_LATENCY-1];
  assign b_rvalid = vld_q[1][READ_LATENCY-1];
  assign a_rdata  = dat_q[0][READ_LATENCY-1];
  assign b_rdata  = dat_q[1][READ_LATENCY-1];

  // Init sequencer: walk every address once, then open both ports.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q   <= INIT_ON_RESET != 0 ? INIT : READY;
      cnt_q     <= '0;
      init_busy <= INIT_ON_RESET != 0;
      ready_q   <= 1'b0;
    end else if (state_q == INIT) begin
      cnt_q <= cnt_q + CNT_ONE;
      if (cnt_q == CNT_LAST) begin
        state_q   <= READY;
        init_busy <= 1'b0;
        ready_q   <= 1'b1;
      end
    end else ready_q <= 1'b1;

  // Storage: zero-fill during init, else lane writes with B applied first so A wins overlapping lanes.
  always_ff @(posedge clk)
    if (state_q == INIT) mem_q[cnt_q[ADDR_SIZE-1:0]] <= '0;
    else
      for (int p = 1; p >= 0; p--)
        for (int i = 0; i < LANES; i++)
          if (wr[p] && be[p][i])
            mem_q[addr[p]][i*LANE_SIZE +: LANE_SIZE] <= wdata[p][i*LANE_SIZE +: LANE_SIZE];

  // Read pipeline: capture pre-write word at acceptance; idle stages carry zero so rdata is 0 without rvalid.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      vld_q <= '0;
      dat_q <= '{default: '0};
    end else
      for (int p = 0; p < 2; p++) begin
        vld_q[p][0] <= rd[p];
        dat_q[p][0] <= rd[p] ? mem_q[addr[p]] : '0;
        for (int s = 1; s < READ_LATENCY; s++) begin
          vld_q[p][s] <= vld_q[p][s-1];
          dat_q[p][s] <= dat_q[p][s-1];
        end
      end
endmodule
